// File: rtl/ground_scroller.sv
// Ground texture row for the Vga controller: once per frame it scrolls the
// pattern left by `speed` bits and feeds LFSR-generated specks in at the right edge.
module ground_scroller #(
  parameter int              WIDTH        = 320,
  parameter logic [15:0]     SEED         = 16'hACE1,
  parameter logic [WIDTH-1:0] INIT_PATTERN = {WIDTH{1'b0}}
) (
  input  logic             vga_clk,
  input  logic             clrn,
  input  logic             vs,
  input  logic             run,
  input  logic [2:0]       speed,
  input  logic             restart,
  output logic [WIDTH-1:0] px_ground,
  output logic             frame_tick,
  output logic             busy,
  output logic [15:0]      distance
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pattern_q, pattern_d;
  logic [15:0]      lfsr_q, lfsr_d;
  logic [15:0]      distance_q, distance_d;
  logic [2:0]       cnt_q, cnt_d;
  logic             vs_prev_q, vs_prev_d;
  logic             frame_tick_q, frame_tick_d;
  logic             busy_q, busy_d;

  logic             frame_start;
  logic             new_bit;
  logic [15:0]      lfsr_next;

  assign frame_start = vs_prev_q & ~vs;
  assign new_bit     = (lfsr_q[3:0] == 4'h0);
  assign lfsr_next   = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

  always_comb begin
    state_d      = state_q;
    pattern_d    = pattern_q;
    lfsr_d       = lfsr_q;
    distance_d   = distance_q;
    cnt_d        = cnt_q;
    busy_d       = busy_q;
    vs_prev_d    = vs;
    frame_tick_d = frame_start;

    // restart overrides everything except the frame edge detector
    if (restart) begin
      state_d    = IDLE;
      pattern_d  = INIT_PATTERN;
      lfsr_d     = SEED;
      distance_d = 16'd0;
      cnt_d      = 3'd0;
      busy_d     = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (frame_start && run && (speed != 3'd0)) begin
            cnt_d   = speed;
            state_d = SHIFT;
            busy_d  = 1'b1;
          end
        end
        SHIFT: begin
          pattern_d  = {new_bit, pattern_q[WIDTH-1:1]};
          lfsr_d     = lfsr_next;
          distance_d = distance_q + 16'd1;
          cnt_d      = cnt_q - 3'd1;
          if (cnt_q == 3'd1) begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge vga_clk or negedge clrn) begin
    if (!clrn) begin
      state_q      <= IDLE;
      pattern_q    <= INIT_PATTERN;
      lfsr_q       <= SEED;
      distance_q   <= 16'd0;
      cnt_q        <= 3'd0;
      busy_q       <= 1'b0;
      vs_prev_q    <= 1'b1;
      frame_tick_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pattern_q    <= pattern_d;
      lfsr_q       <= lfsr_d;
      distance_q   <= distance_d;
      cnt_q        <= cnt_d;
      busy_q       <= busy_d;
      vs_prev_q    <= vs_prev_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign px_ground  = pattern_q;
  assign frame_tick = frame_tick_q;
  assign busy       = busy_q;
  assign distance   = distance_q;

endmodule

// File: tb/tb_ground_scroller.sv
// Directed self-checking bench for ground_scroller: frame scrolling, hold,
// mid-frame speed changes, restart, distance wrap and async reset.
module tb_ground_scroller;

  localparam int          W    = 320;
  localparam logic [15:0] SEED = 16'hACE1;
  localparam logic [W-1:0] INIT = {1'b1, {(W-1){1'b0}}};

  logic         vga_clk = 1'b0;
  logic         clrn    = 1'b0;
  logic         vs      = 1'b1;
  logic         run     = 1'b0;
  logic [2:0]   speed   = 3'd0;
  logic         restart = 1'b0;
  logic [W-1:0] px_ground;
  logic         frame_tick;
  logic         busy;
  logic [15:0]  distance;

  int vectors = 0;
  int miscompares = 0;

  logic [W-1:0] m_pat;
  logic [15:0]  m_lfsr;
  logic [15:0]  m_dist;

  ground_scroller #(.WIDTH(W), .SEED(SEED), .INIT_PATTERN(INIT)) dut (
    .vga_clk(vga_clk), .clrn(clrn), .vs(vs), .run(run), .speed(speed),
    .restart(restart), .px_ground(px_ground), .frame_tick(frame_tick),
    .busy(busy), .distance(distance)
  );

  always #5 vga_clk = ~vga_clk;

  task automatic checkOutput(input string tag, input logic [W-1:0] observed,
                             input logic [W-1:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    m_pat  = INIT;
    m_lfsr = SEED;
    m_dist = 16'd0;
  endtask

  task automatic modelShift(input int n);
    logic nb;
    for (int i = 0; i < n; i++) begin
      nb     = (m_lfsr[3:0] == 4'h0);
      m_pat  = {nb, m_pat[W-1:1]};
      m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
      m_dist = m_dist + 16'd1;
    end
  endtask

  // One frame: vs falls, speed optionally changes once the frame has started;
  // counts frame_tick and busy cycles. Entered and left at posedge+1.
  task automatic applyStimulus(input logic r, input logic [2:0] spd, input logic [2:0] mid_spd,
                               output int ticks, output int busy_cycles);
    ticks = 0;
    busy_cycles = 0;
    run = r;
    speed = spd;
    vs = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge vga_clk);
      if (frame_tick) ticks++;
      if (busy) busy_cycles++;
      if (i == 1) speed = mid_spd;
      if (i == 2) vs = 1'b1;
    end
    @(posedge vga_clk); #1;
  endtask

  initial begin
    int ticks, bc, total_ticks, total_busy;
    logic [15:0] dist_before;
    logic [W-1:0] pat_before;

    modelReset();
    repeat (3) @(negedge vga_clk);
    checkOutput("reset_px", px_ground, INIT);
    checkOutput("reset_dist", W'(distance), W'(16'd0));
    checkOutput("reset_busy", W'(busy), W'(1'b0));
    checkOutput("reset_tick", W'(frame_tick), W'(1'b0));
    clrn = 1'b1;
    @(posedge vga_clk); #1;

    total_ticks = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge vga_clk);
      if (frame_tick) total_ticks++;
    end
    checkOutput("idle_no_tick", W'(total_ticks), W'(0));
    @(posedge vga_clk); #1;

    applyStimulus(1'b1, 3'd3, 3'd3, ticks, bc);
    modelShift(3);
    checkOutput("s3_ticks", W'(ticks), W'(1));
    checkOutput("s3_busy", W'(bc), W'(3));
    checkOutput("s3_px_hand", px_ground, {3'b000, 1'b1, {(W-4){1'b0}}});
    checkOutput("s3_px_model", px_ground, m_pat);
    checkOutput("s3_dist", W'(distance), W'(16'd3));

    total_ticks = 0;
    total_busy = 0;
    pat_before = px_ground;
    dist_before = distance;
    for (int f = 0; f < 5; f++) begin
      applyStimulus(f[0], (f == 4) ? 3'd5 : 3'd0, 3'd0, ticks, bc);
      total_ticks += ticks;
      total_busy += bc;
    end
    checkOutput("hold_ticks", W'(total_ticks), W'(5));
    checkOutput("hold_busy", W'(total_busy), W'(0));
    checkOutput("hold_px", px_ground, pat_before);
    checkOutput("hold_dist", W'(distance), W'(dist_before));

    applyStimulus(1'b1, 3'd7, 3'd1, ticks, bc);
    modelShift(7);
    checkOutput("s7_busy", W'(bc), W'(7));
    checkOutput("s7_dist", W'(distance), W'(16'd10));
    checkOutput("s7_px", px_ground, m_pat);

    applyStimulus(1'b1, 3'd1, 3'd1, ticks, bc);
    modelShift(1);
    checkOutput("s1_busy", W'(bc), W'(1));
    checkOutput("s1_dist", W'(distance), W'(16'd11));
    checkOutput("s1_px", px_ground, m_pat);

    // restart during the second SHIFT cycle of a speed=5 frame
    run = 1'b1;
    speed = 3'd5;
    vs = 1'b0;
    @(posedge vga_clk); #1;
    vs = 1'b1;
    @(posedge vga_clk); #1;
    restart = 1'b1;
    @(posedge vga_clk); #1;
    restart = 1'b0;
    @(negedge vga_clk);
    checkOutput("rst_px", px_ground, INIT);
    checkOutput("rst_dist", W'(distance), W'(16'd0));
    checkOutput("rst_busy", W'(busy), W'(1'b0));
    repeat (8) @(negedge vga_clk);
    checkOutput("rst_no_more_shift", W'(distance), W'(16'd0));
    modelReset();
    @(posedge vga_clk); #1;

    applyStimulus(1'b1, 3'd2, 3'd2, ticks, bc);
    modelShift(2);
    checkOutput("post_rst_px", px_ground, m_pat);
    checkOutput("post_rst_dist", W'(distance), W'(16'd2));

    restart = 1'b1;
    @(posedge vga_clk); #1;
    restart = 1'b0;
    run = 1'b1;
    speed = 3'd7;
    for (int f = 0; f < 9363; f++) begin
      vs = 1'b0;
      @(posedge vga_clk); #1;
      vs = 1'b1;
      repeat (7) @(posedge vga_clk);
      #1;
    end
    repeat (2) @(negedge vga_clk);
    checkOutput("wrap_dist", W'(distance), W'(16'd5));
    checkOutput("wrap_busy", W'(busy), W'(1'b0));
    @(posedge vga_clk); #1;

    // async reset in the middle of a speed=7 frame
    vs = 1'b0;
    @(posedge vga_clk); #1;
    vs = 1'b1;
    @(posedge vga_clk); #1;
    @(posedge vga_clk); #1;
    checkOutput("mid_busy_pre", W'(busy), W'(1'b1));
    #1 clrn = 1'b0;
    #1;
    checkOutput("async_px", px_ground, INIT);
    checkOutput("async_dist", W'(distance), W'(16'd0));
    checkOutput("async_busy", W'(busy), W'(1'b0));
    checkOutput("async_tick", W'(frame_tick), W'(1'b0));
    repeat (2) @(posedge vga_clk);
    #1 clrn = 1'b1;
    repeat (3) @(negedge vga_clk);
    checkOutput("after_async_dist", W'(distance), W'(16'd0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
